// File: rtl/vm1_bus_pkg.sv
// vm1_bus_pkg: arbiter state encoding, bus control bit positions and strobe helper.
package vm1_bus_pkg;

    typedef enum logic [1:0] {
        ST_CPU   = 2'd0,
        ST_GRANT = 2'd1,
        ST_DMA   = 2'd2,
        ST_REL   = 2'd3
    } bus_state_e;

    localparam int CTL_WTBT = 2;
    localparam int CTL_DOUT = 1;
    localparam int CTL_DIN  = 0;

    function automatic logic is_strobe(input logic [2:0] ctl);
        return ctl[CTL_DIN] | ctl[CTL_DOUT];
    endfunction

endpackage

// File: rtl/vm1_rr_pick2.sv
// vm1_rr_pick2: two-way round-robin pick; on a tie the master not served last wins.
module vm1_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    assign gnt_o = (req_i == 2'b11) ? (last_i ? 2'b01 : 2'b10) : req_i;
    assign idx_o = gnt_o[1];

endmodule

// File: rtl/vm1_bus_arbiter.sv
// vm1_bus_arbiter: shares one Q-bus style bus between the CPU (default owner) and two DMA masters.
// Define VM1_BUS_TIMEOUT_EN to add the missing-RPLY timeout (CPU error pulse / forced DMA release).
module vm1_bus_arbiter
    import vm1_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int BURST_MAX      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] cpu_addr_i,
    input  logic [15:0] cpu_data_i,
    input  logic [2:0]  cpu_ctl_i,
    output logic [15:0] cpu_data_o,
    output logic        cpu_rply_o,
    output logic        cpu_error_o,
    input  logic [1:0]  dma_req_i,
    output logic [1:0]  dma_gnt_o,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_data_i,
    input  logic [5:0]  dma_ctl_i,
    output logic [15:0] dma_data_o,
    output logic [1:0]  dma_rply_o,
    output logic [15:0] bus_addr_o,
    output logic [15:0] bus_data_o,
    output logic [2:0]  bus_ctl_o,
    input  logic [15:0] bus_data_i,
    input  logic        bus_rply_i
);

    localparam int CW = $clog2(BURST_MAX + 1);

    bus_state_e    state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic [1:0]    pick_gnt;
    logic          pick_idx;
    logic          m;
    logic [2:0]    m_ctl;
    logic          m_stb;
    logic          cpu_stb;
    logic          bus_stb;
    logic          tmo_hit;

    vm1_rr_pick2 u_pick (
        .req_i  (dma_req_i),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    assign m       = gnt_q[1];
    assign m_ctl   = m ? dma_ctl_i[5:3] : dma_ctl_i[2:0];
    assign m_stb   = is_strobe(m_ctl);
    assign cpu_stb = is_strobe(cpu_ctl_i);

    assign bus_ctl_o  = (state_q == ST_CPU) ? cpu_ctl_i : (state_q == ST_DMA) ? m_ctl : 3'b000;
    assign bus_addr_o = (state_q == ST_DMA) ? (m ? dma_addr_i[31:16] : dma_addr_i[15:0]) : cpu_addr_i;
    assign bus_data_o = (state_q == ST_DMA) ? (m ? dma_data_i[31:16] : dma_data_i[15:0]) : cpu_data_i;
    assign bus_stb    = is_strobe(bus_ctl_o);
    assign cpu_data_o = bus_data_i;
    assign dma_data_o = bus_data_i;
    assign cpu_rply_o = (state_q == ST_CPU) && bus_rply_i;
    assign dma_rply_o = (state_q == ST_DMA) ? (gnt_q & {2{bus_rply_i}}) : 2'b00;
    assign dma_gnt_o  = gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        case (state_q)
            ST_CPU: begin
                if (|dma_req_i && !cpu_stb) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                cnt_d  = '0;
                seen_d = 1'b0;
                if (|dma_req_i) begin
                    state_d = ST_DMA;
                    gnt_d   = pick_gnt;
                    last_d  = pick_idx;
                end else begin
                    state_d = ST_CPU;
                end
            end
            ST_DMA: begin
                // A bus cycle completes when the strobe falls after RPLY was seen.
                seen_d = m_stb && (seen_q || bus_rply_i);
                if (seen_q && !m_stb && cnt_q != CW'(BURST_MAX)) cnt_d = cnt_q + 1'b1;
                if ((!m_stb && (!dma_req_i[m] || cnt_d == CW'(BURST_MAX))) || tmo_hit) begin
                    state_d = ST_REL;
                    gnt_d   = 2'b00;
                end
            end
            default: state_d = ST_CPU;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CPU;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

`ifdef VM1_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          stb_q;
    logic          err_q, err_d;

    // Counter saturates at the limit so a stuck strobe raises only one event.
    always_comb begin
        tmo_d = (!bus_stb || !stb_q) ? '0 : tmo_q;
        if (bus_stb && !bus_rply_i && tmo_d != TW'(TIMEOUT_CYCLES)) tmo_d = tmo_d + 1'b1;
        tmo_hit = (tmo_d == TW'(TIMEOUT_CYCLES)) && (tmo_q != TW'(TIMEOUT_CYCLES));
        err_d   = tmo_hit && (state_q == ST_CPU);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
            stb_q <= 1'b0;
            err_q <= 1'b0;
        end else if (ce) begin
            tmo_q <= tmo_d;
            stb_q <= bus_stb;
            err_q <= err_d;
        end
    end

    assign cpu_error_o = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign cpu_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_vm1_bus_arbiter.sv
// tb_vm1_bus_arbiter: directed vectors with hand-computed expectations for vm1_bus_arbiter.
module tb_vm1_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic [15:0] cpu_addr_i = '0;
    logic [15:0] cpu_data_i = '0;
    logic [2:0]  cpu_ctl_i = '0;
    logic [15:0] cpu_data_o;
    logic        cpu_rply_o;
    logic        cpu_error_o;
    logic [1:0]  dma_req_i = '0;
    logic [1:0]  dma_gnt_o;
    logic [31:0] dma_addr_i = '0;
    logic [31:0] dma_data_i = '0;
    logic [5:0]  dma_ctl_i = '0;
    logic [15:0] dma_data_o;
    logic [1:0]  dma_rply_o;
    logic [15:0] bus_addr_o;
    logic [15:0] bus_data_o;
    logic [2:0]  bus_ctl_o;
    logic [15:0] bus_data_i = '0;
    logic        bus_rply_i = 1'b0;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vm1_bus_arbiter #(.TIMEOUT_CYCLES(64), .BURST_MAX(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_ctl_i   (cpu_ctl_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_rply_o  (cpu_rply_o),
        .cpu_error_o (cpu_error_o),
        .dma_req_i   (dma_req_i),
        .dma_gnt_o   (dma_gnt_o),
        .dma_addr_i  (dma_addr_i),
        .dma_data_i  (dma_data_i),
        .dma_ctl_i   (dma_ctl_i),
        .dma_data_o  (dma_data_o),
        .dma_rply_o  (dma_rply_o),
        .bus_addr_o  (bus_addr_o),
        .bus_data_o  (bus_data_o),
        .bus_ctl_o   (bus_ctl_o),
        .bus_data_i  (bus_data_i),
        .bus_rply_i  (bus_rply_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_write();
        dma_ctl_i[2:0] = 3'b010;
        step();
        bus_rply_i = 1'b1;
        step();
        dma_ctl_i[2:0] = 3'b000;
        bus_rply_i = 1'b0;
        step();
    endtask

    initial begin
        #1;
        check("reset_gnt", dma_gnt_o, 2'b00);
        check("reset_err", cpu_error_o, 1'b0);
        check("reset_ctl", bus_ctl_o, 3'b000);
        #8 reset_n = 1'b1;
        step();

        // CPU read of 0o177716 with RPLY after three cycles
        cpu_addr_i = 16'o177716;
        cpu_ctl_i  = 3'b001;
        #1;
        check("cpu_rd_addr", bus_addr_o, 16'hFFCE);
        check("cpu_rd_ctl", bus_ctl_o, 3'b001);
        check("cpu_rd_no_rply", cpu_rply_o, 1'b0);
        repeat (3) step();
        bus_rply_i = 1'b1;
        bus_data_i = 16'h1234;
        #1;
        check("cpu_rd_rply", cpu_rply_o, 1'b1);
        check("cpu_rd_data", cpu_data_o, 16'h1234);
        check("cpu_rd_gnt", dma_gnt_o, 2'b00);
        check("cpu_rd_dma_rply", dma_rply_o, 2'b00);
        step();
        cpu_ctl_i  = 3'b000;
        bus_rply_i = 1'b0;
        step();

        // Tie from reset: master0 first, master1 after REL
        dma_addr_i = {16'hA1A1, 16'hA0A0};
        dma_data_i = {16'hD1D1, 16'hD0D0};
        cpu_ctl_i  = 3'b100;
        dma_req_i  = 2'b11;
        step();
        check("tie_grant_ctl", bus_ctl_o, 3'b000);
        check("tie_grant_gnt", dma_gnt_o, 2'b00);
        step();
        check("tie_first_gnt", dma_gnt_o, 2'b01);
        dma_ctl_i  = 6'b001_010;
        bus_rply_i = 1'b1;
        #1;
        check("m0_addr", bus_addr_o, 16'hA0A0);
        check("m0_data", bus_data_o, 16'hD0D0);
        check("m0_ctl_m1_ignored", bus_ctl_o, 3'b010);
        check("m0_rply", dma_rply_o, 2'b01);
        check("m0_cpu_stall", cpu_rply_o, 1'b0);
        step();
        dma_ctl_i  = 6'b000_000;
        bus_rply_i = 1'b0;
        dma_req_i  = 2'b10;
        step();
        check("rel_gnt", dma_gnt_o, 2'b00);
        check("rel_ctl", bus_ctl_o, 3'b000);
        step();
        check("back_cpu_ctl", bus_ctl_o, 3'b100);
        begin
            int waited = 0;
            while (dma_gnt_o !== 2'b10 && waited < 10) begin
                step();
                waited++;
            end
            check("tie_second_gnt", dma_gnt_o, 2'b10);
        end
        check("m1_addr", bus_addr_o, 16'hA1A1);
        dma_req_i = 2'b00;
        step();
        step();

        // Burst limit: release after the 8th completed write
        dma_req_i = 2'b01;
        step();
        step();
        check("burst_gnt", dma_gnt_o, 2'b01);
        for (int i = 0; i < 8; i++) begin
            m0_write();
            if (i == 6) check("burst_7_held", dma_gnt_o, 2'b01);
        end
        check("burst_8_rel_gnt", dma_gnt_o, 2'b00);
        check("burst_8_rel_ctl", bus_ctl_o, 3'b000);
        step();
        check("burst_cpu_ctl", bus_ctl_o, 3'b100);
        check("burst_cpu_gnt", dma_gnt_o, 2'b00);
        step();
        check("burst_regrant_ctl", bus_ctl_o, 3'b000);
        step();
        check("burst_regrant_gnt", dma_gnt_o, 2'b01);
        dma_req_i = 2'b00;
        step();
        step();
        cpu_ctl_i = 3'b000;

        // DMA request while the CPU read is active
        cpu_addr_i = 16'o177560;
        cpu_ctl_i  = 3'b001;
        dma_req_i  = 2'b01;
        repeat (3) step();
        check("cpu_busy_gnt", dma_gnt_o, 2'b00);
        check("cpu_busy_ctl", bus_ctl_o, 3'b001);
        bus_rply_i = 1'b1;
        #1;
        check("cpu_busy_rply", cpu_rply_o, 1'b1);
        step();
        cpu_ctl_i  = 3'b000;
        bus_rply_i = 1'b0;
        step();
        check("after_din_grant", dma_gnt_o, 2'b00);
        step();
        check("after_din_gnt", dma_gnt_o, 2'b01);
        bus_rply_i = 1'b1;
        #1;
        check("dma_owner_cpu_rply", cpu_rply_o, 1'b0);
        bus_rply_i = 1'b0;
        ce        = 1'b0;
        dma_req_i = 2'b00;
        repeat (3) step();
        check("ce_hold_gnt", dma_gnt_o, 2'b01);
        ce = 1'b1;
        step();
        check("ce_resume_rel", dma_gnt_o, 2'b00);
        step();

        // Asynchronous reset in the middle of a DMA read
        dma_req_i = 2'b01;
        step();
        step();
        check("pre_reset_gnt", dma_gnt_o, 2'b01);
        dma_ctl_i = 6'b000_001;
        #1;
        check("pre_reset_ctl", bus_ctl_o, 3'b001);
        reset_n = 1'b0;
        #1;
        check("async_reset_gnt", dma_gnt_o, 2'b00);
        check("async_reset_ctl", bus_ctl_o, 3'b000);
        check("async_reset_rply", dma_rply_o, 2'b00);
        dma_ctl_i = 6'b000_000;
        dma_req_i = 2'b00;
        step();
        reset_n = 1'b1;
        step();

        // CPU strobe with no RPLY
        cpu_ctl_i = 3'b001;
`ifdef VM1_BUS_TIMEOUT_EN
        begin
            int lat = 0;
            for (int i = 1; i <= 100 && lat == 0; i++) begin
                step();
                if (cpu_error_o) lat = i;
            end
            check("tmo_latency", lat, 64);
            step();
            check("tmo_pulse_width", cpu_error_o, 1'b0);
        end
`else
        begin
            int hi = 0;
            for (int i = 0; i < 80; i++) begin
                step();
                if (cpu_error_o) hi++;
            end
            check("no_tmo_err", hi, 0);
            check("no_tmo_stall_ctl", bus_ctl_o, 3'b001);
        end
`endif
        cpu_ctl_i = 3'b000;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
